// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and constants for the sequential divider.
// Holds the FSM state enum, default widths and the divide-by-zero quotient.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_OUT_WIDTH = 32;

  localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result handshake bundle for seq_divider.
// Ports: in_valid/in_ready/dividend/divisor (request), out_valid/
// out_ready/quotient/remainder/err (result); master = requester, slave = divider.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] quotient;
  logic [OUT_WIDTH-1:0] remainder;
  logic                 err;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, err
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, err
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step.
// Ports: rem_i (partial remainder), bit_i (next dividend bit), divisor_i;
// rem_o (next partial remainder), q_o (quotient bit).
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  assign shifted = {rem_i, bit_i};
  // rem_i < divisor_i, so a successful difference always fits in WIDTH bits.
  assign trial   = shifted[WIDTH-1:0] - divisor_i;
  assign q_o     = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_o ? trial : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Ports: clk, rst (async, active-high), bus (seq_divider_if.slave handshake).
// Macro SEQ_DIVIDER_SIGNED_EN selects two's-complement operands and results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  // All-ones stays all-ones under sign extension or truncation.
  localparam logic [WIDTH-1:0] DIV0_Q = WIDTH'($signed(DIV0_QUOTIENT));

  function automatic logic [OUT_WIDTH-1:0] ext(input logic [WIDTH-1:0] v);
`ifdef SEQ_DIVIDER_SIGNED_EN
    return OUT_WIDTH'($signed(v));
`else
    return OUT_WIDTH'(v);
`endif
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic [OUT_WIDTH-1:0] quot_q, quot_d;
  logic [OUT_WIDTH-1:0] remd_q, remd_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0]     step_rem;
  logic                 step_q;
  logic [WIDTH-1:0]     fin_q;
  logic [WIDTH-1:0]     a_in, b_in;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .bit_i    (shift_q[WIDTH-1]),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  // Quotient bits enter at the LSB as dividend bits leave the MSB.
  assign fin_q = {shift_q[WIDTH-2:0], step_q};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic ovf_q, ovf_d;
  logic a_neg, b_neg;

  assign a_neg = bus.dividend[WIDTH-1];
  assign b_neg = bus.divisor[WIDTH-1];
  assign a_in  = a_neg ? -bus.dividend : bus.dividend;
  assign b_in  = b_neg ? -bus.divisor : bus.divisor;
`else
  assign a_in  = bus.dividend;
  assign b_in  = bus.divisor;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    err_d   = err_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            state_d = DONE;
            quot_d  = ext(DIV0_Q);
            remd_d  = ext(bus.dividend);
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
            count_d = '0;
            rem_d   = '0;
            shift_d = a_in;
            dvsr_d  = b_in;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            // Most negative / -1 is the only unrepresentable quotient.
            ovf_d   = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                    && (bus.divisor == '1);
`endif
          end
        end
      end
      RUN: begin
        shift_d = fin_q;
        rem_d   = step_rem;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
          quot_d  = ext(qneg_q ? -fin_q : fin_q);
          remd_d  = ext(rneg_q ? -step_rem : step_rem);
          err_d   = ovf_q;
`else
          quot_d  = ext(fin_q);
          remd_d  = ext(step_rem);
          err_d   = 1'b0;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      err_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      err_q   <= err_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = remd_q;
  assign bus.err       = err_q;

endmodule
